seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Recovers four BCD digits from a multiplexed, active-low
//            7-segment display bus (segments + digit strobes) sampled
//            asynchronously. Each strobed slot is captured once its pins
//            have stayed stable for STABLE_CYCLES synchronized samples.
// Options  : SEG_SCAN_DECODER_BLANK_EN - when defined, the all-off segment
//            pattern decodes as a valid blank digit (code 4'hF).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  // The settle counter reaches CNT_MAX on the capture edge: the entry sample
  // plus STABLE_CYCLES-1 equal repeats make STABLE_CYCLES equal samples.
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 2);
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [10:0] sync1_q;
  logic [10:0] sync2_q;
  logic [10:0] prev_q;
  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  seen_q;
  logic [15:0] digits_q;
  logic [3:0]  valid_q;
  logic        frame_done_q;
  logic        err_q;

  logic [3:0]  an_s;
  logic [6:0]  seg_s;
  logic        changed;
  logic        one_hot;
  logic [3:0]  slot_sel;
  logic [3:0]  seen_d;
  logic [3:0]  dec_code;
  logic        dec_ok;

  assign an_s     = sync2_q[10:7];
  assign seg_s    = sync2_q[6:0];
  assign changed  = (sync2_q != prev_q);
  assign slot_sel = ~an_s;
  assign seen_d   = seen_q | slot_sel;

  // Exactly one strobe low selects a slot; anything else is an idle bus.
  always_comb begin
    one_hot = 1'b0;
    case (an_s)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_hot = 1'b1;
      default:                            one_hot = 1'b0;
    endcase
  end

  // Active-low segment pattern (a..g) to BCD code.
  always_comb begin
    dec_ok   = 1'b1;
    dec_code = 4'h0;
    case (seg_s)
      7'b0000001: dec_code = 4'h0;
      7'b1001111: dec_code = 4'h1;
      7'b0010010: dec_code = 4'h2;
      7'b0000110: dec_code = 4'h3;
      7'b1001100: dec_code = 4'h4;
      7'b0100100: dec_code = 4'h5;
      7'b0100000: dec_code = 4'h6;
      7'b0001111: dec_code = 4'h7;
      7'b0000000: dec_code = 4'h8;
      7'b0000100: dec_code = 4'h9;
`ifdef SEG_SCAN_DECODER_BLANK_EN
      7'b1111111: dec_code = 4'hF;
`endif
      default: begin
        dec_ok   = 1'b0;
        dec_code = 4'h0;
      end
    endcase
  end

  // Two-flop synchronizer for the pins plus the one-sample history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= {an, seg};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Settle/capture FSM with registered digit, valid, frame and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      seen_q       <= 4'b0000;
      digits_q     <= 16'h0000;
      valid_q      <= 4'b0000;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      if (changed) begin
        // Any movement on the pins restarts settling from scratch.
        cnt_q <= 8'd0;
        if (one_hot) begin
          state_q <= SETTLE;
        end else begin
          state_q <= IDLE;
        end
      end else if (state_q == SETTLE) begin
        if (cnt_q == CNT_CAP) begin
          state_q <= HELD;
          cnt_q   <= CNT_MAX;
          for (int i = 0; i < 4; i++) begin
            if (slot_sel[i]) begin
              if (dec_ok) begin
                digits_q[4*i +: 4] <= dec_code;
                valid_q[i]         <= 1'b1;
              end else begin
                valid_q[i] <= 1'b0;
              end
            end
          end
          if (!dec_ok) begin
            err_q <= 1'b1;
          end
          if (seen_d == 4'b1111) begin
            frame_done_q <= 1'b1;
            seen_q       <= 4'b0000;
          end else begin
            seen_q <= seen_d;
          end
        end else if (cnt_q < CNT_MAX) begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;

endmodule

`default_nettype wire
